// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: main FSM, ALU decoder, condition check and NZCV flags.
// Define CMP_TST_EN to decode funct 1010/1000 as CMP/TST; otherwise they are unimplemented.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  state_t      state_reg, state_next;
  logic [3:0]  flags_reg;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic        rd_is_pc;
  logic        is_load;
  logic        is_store;
  logic        unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign rd_is_pc  = (rd == 4'hF);
  assign is_load   = funct[0];
  assign is_store  = (op == 2'b01) && !funct[0];
  assign unused_rn = ^Instr[7:4];

  // ALU decoder: data-processing command field funct[4:1].
  logic [1:0] dec_alu;
  logic       dec_reg_write;
  logic       dec_flag_ok;
  logic       dec_cv_update;

  always_comb begin
    dec_alu       = ALU_ADD;
    dec_reg_write = 1'b0;
    dec_flag_ok   = 1'b0;
    dec_cv_update = 1'b0;
    case (funct[4:1])
      4'b0100: begin
        dec_alu       = ALU_ADD;
        dec_reg_write = 1'b1;
        dec_flag_ok   = 1'b1;
        dec_cv_update = 1'b1;
      end
      4'b0010: begin
        dec_alu       = ALU_SUB;
        dec_reg_write = 1'b1;
        dec_flag_ok   = 1'b1;
        dec_cv_update = 1'b1;
      end
      4'b0000: begin
        dec_alu       = ALU_AND;
        dec_reg_write = 1'b1;
        dec_flag_ok   = 1'b1;
      end
      4'b1100: begin
        dec_alu       = ALU_ORR;
        dec_reg_write = 1'b1;
        dec_flag_ok   = 1'b1;
      end
`ifdef CMP_TST_EN
      4'b1010: begin
        dec_alu       = ALU_SUB;
        dec_flag_ok   = 1'b1;
        dec_cv_update = 1'b1;
      end
      4'b1000: begin
        dec_alu       = ALU_AND;
        dec_flag_ok   = 1'b1;
      end
`endif
      default: begin
        dec_alu       = ALU_ADD;
      end
    endcase
  end

  // Condition check against the registered flags only, so outputs stay Moore.
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_reg;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = !flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = !flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = !flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = !flag_v;
      4'b1000: cond_ex = flag_c && !flag_z;
      4'b1001: cond_ex = !flag_c || flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ex = flag_z || (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flags capture the ALU result on the edge that ends the execute state.
  logic in_exec;
  logic flag_we;

  assign in_exec = (state_reg == EXECR) || (state_reg == EXECI);
  assign flag_we = in_exec && funct[0] && dec_flag_ok && cond_ex;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg <= 4'b0000;
    end else if (flag_we) begin
      flags_reg[3:2] <= ALUFlags[3:2];
      if (dec_cv_update) begin
        flags_reg[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          2'b00:   state_next = funct[5] ? EXECI : EXECR;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: state_next = is_load ? MEMRD : MEMWR;
      MEMRD:  state_next = MEMWB;
      MEMWB:  state_next = FETCH;
      MEMWR:  state_next = FETCH;
      EXECR,
      EXECI:  state_next = dec_reg_write ? ALUWB : FETCH;
      ALUWB:  state_next = FETCH;
      BRANCH: state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  logic       pc_we, mem_we, ir_we, reg_we;
  logic       adr_src, alu_src_a;
  logic [1:0] result_src, alu_src_b, imm_src, alu_control;

  always_comb begin
    pc_we       = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    reg_we      = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    result_src  = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    alu_control = ALU_ADD;
    case (state_reg)
      FETCH: begin
        ir_we      = 1'b1;
        pc_we      = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        imm_src   = 2'b01;
      end
      MEMRD: begin
        adr_src = 1'b1;
      end
      MEMWR: begin
        adr_src = 1'b1;
        mem_we  = cond_ex;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_we     = cond_ex;
        pc_we      = cond_ex && rd_is_pc;
      end
      EXECR: begin
        alu_control = dec_alu;
      end
      EXECI: begin
        alu_src_b   = 2'b01;
        alu_control = dec_alu;
      end
      ALUWB: begin
        reg_we = cond_ex;
        pc_we  = cond_ex && rd_is_pc;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        imm_src    = 2'b10;
        result_src = 2'b10;
        pc_we      = cond_ex;
      end
      default: begin
        pc_we = 1'b0;
      end
    endcase
  end

  // Write enables are killed while reset is held so no pending write escapes.
  assign PCWrite    = pc_we  && !reset;
  assign MemWrite   = mem_we && !reset;
  assign IRWrite    = ir_we  && !reset;
  assign RegWrite   = reg_we && !reset;
  assign AdrSrc     = adr_src;
  assign ALUSrcA    = alu_src_a;
  assign ResultSrc  = result_src;
  assign ALUSrcB    = alu_src_b;
  assign ImmSrc     = imm_src;
  assign ALUControl = alu_control;
  assign RegSrc     = {is_store, (state_reg == BRANCH)};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, reset corners, and random
// instructions checked against a per-instruction cycle-list reference model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

`ifdef CMP_TST_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb, imm, regsrc, aluc;
  } ctl_t;

  typedef struct {
    logic [19:0] instr;
    logic [3:0]  fl;
    int          cyc;
    bit          rw, mw, pcw;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] mflags;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic ctl_t act();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ImmSrc, RegSrc, ALUControl};
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Condition codes come in true/negated pairs; 1110 always, 1111 never.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, base;
    {n, z, cc, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  function automatic void dp_info(input logic [3:0] cmd, output logic [1:0] alu,
                                  output bit wr, output bit fl, output bit cv);
    alu = 2'b00; wr = 0; fl = 0; cv = 0;
    if (cmd == 4'b0100) begin alu = 2'b00; wr = 1; fl = 1; cv = 1; end
    else if (cmd == 4'b0010) begin alu = 2'b01; wr = 1; fl = 1; cv = 1; end
    else if (cmd == 4'b0000) begin alu = 2'b10; wr = 1; fl = 1; end
    else if (cmd == 4'b1100) begin alu = 2'b11; wr = 1; fl = 1; end
    else if (CMP_EN && cmd == 4'b1010) begin alu = 2'b01; fl = 1; cv = 1; end
    else if (CMP_EN && cmd == 4'b1000) begin alu = 2'b10; fl = 1; end
  endfunction

  // Reference: list the control word of every cycle of one instruction, then
  // compare cycle by cycle. Starts and ends in the low phase of a FETCH cycle.
  task automatic run_model(input logic [19:0] ins, input logic [3:0] fl, input bit fixed);
    ctl_t       q[$];
    ctl_t       base, c;
    logic [1:0] op, alu;
    logic [5:0] funct;
    bit         ce, rd15, wr, fok, cv;
    int         exec_idx;
    logic [3:0] f;
    op       = ins[15:14];
    funct    = ins[13:8];
    rd15     = (ins[3:0] == 4'hF);
    ce       = cond_ok(ins[19:16], mflags);
    exec_idx = -1;
    dp_info(funct[4:1], alu, wr, fok, cv);
    base = '0;
    base.regsrc[1] = (op == 2'b01) && !funct[0];
    c = base; c.pcw = 1; c.irw = 1; c.srca = 1; c.srcb = 2'b10; c.res = 2'b10; q.push_back(c);
    c = base; c.srca = 1; c.srcb = 2'b10; c.res = 2'b10; q.push_back(c);
    if (op == 2'b00) begin
      c = base; c.srcb = funct[5] ? 2'b01 : 2'b00; c.aluc = alu; q.push_back(c);
      exec_idx = 2;
      if (wr) begin
        c = base; c.rw = ce; c.pcw = ce && rd15; q.push_back(c);
      end
    end else if (op == 2'b01) begin
      c = base; c.srcb = 2'b01; c.imm = 2'b01; q.push_back(c);
      if (funct[0]) begin
        c = base; c.adr = 1; q.push_back(c);
        c = base; c.res = 2'b01; c.rw = ce; c.pcw = ce && rd15; q.push_back(c);
      end else begin
        c = base; c.adr = 1; c.mw = ce; q.push_back(c);
      end
    end else if (op == 2'b10) begin
      c = base; c.srcb = 2'b01; c.imm = 2'b10; c.res = 2'b10; c.pcw = ce; c.regsrc[0] = 1;
      q.push_back(c);
    end
    for (int k = 0; k < q.size(); k++) begin
      if (k > 0) next_cycle();
      if (k == 0) Instr = ins;
      f = fixed ? fl : 4'($urandom);
      ALUFlags = f;
      #1;
      chk($sformatf("model instr=%h cyc%0d", ins, k), 32'(act()), 32'(q[k]));
      if (k == exec_idx && fok && funct[0] && ce) begin
        mflags[3:2] = f[3:2];
        if (cv) mflags[1:0] = f[1:0];
      end
    end
    $display("model instr=%h cycles=%0d condex=%0d flags=%b", ins, q.size(), ce, mflags);
    next_cycle();
  endtask

  // Table run: count cycles until the next IRWrite and collect write enables.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bit rw, mw, pcw, done;
    Instr = v.instr;
    ALUFlags = v.fl;
    #1;
    chk($sformatf("vec%0d fetch irw", idx), 32'(IRWrite), 32'd1);
    n = 1; rw = 0; mw = 0; pcw = 0; done = 0;
    while (!done && n < 12) begin
      next_cycle();
      if (IRWrite) done = 1;
      else begin
        rw |= RegWrite; mw |= MemWrite; pcw |= PCWrite;
        n++;
      end
    end
    chk($sformatf("vec%0d cycles", idx), 32'(n), 32'(v.cyc));
    chk($sformatf("vec%0d regwrite", idx), 32'(rw), 32'(v.rw));
    chk($sformatf("vec%0d memwrite", idx), 32'(mw), 32'(v.mw));
    chk($sformatf("vec%0d pcwrite", idx), 32'(pcw), 32'(v.pcw));
    $display("vec%0d instr=%h cycles=%0d rw=%0d mw=%0d pcw=%0d", idx, v.instr, n, rw, mw, pcw);
  endtask

  vec_t vecs[25];
  vec_t v_after_rst;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{20'hE2802, 4'b0000, 4, 1'b1, 1'b0, 1'b0};  // ADD R2,R0,#5
    vecs[1]  = '{20'hE0523, 4'b0100, 4, 1'b1, 1'b0, 1'b0};  // SUBS -> Z=1
    vecs[2]  = '{20'h02804, 4'b0000, 4, 1'b1, 1'b0, 1'b0};  // ADDEQ taken
    vecs[3]  = '{20'hE2905, 4'b0000, 4, 1'b1, 1'b0, 1'b0};  // ADDS -> 0000
    vecs[4]  = '{20'h02804, 4'b0000, 4, 1'b0, 1'b0, 1'b0};  // ADDEQ not taken
    vecs[5]  = '{20'hE1510, 4'b0100, 3, 1'b0, 1'b0, 1'b0};  // CMP R1,R1
    vecs[6]  = '{20'h02804, 4'b0000, 4, CMP_EN, 1'b0, 1'b0};
    vecs[7]  = '{20'hE5837, 4'b0000, 4, 1'b0, 1'b1, 1'b0};  // STR
    vecs[8]  = '{20'hE5938, 4'b0000, 5, 1'b1, 1'b0, 1'b0};  // LDR
    vecs[9]  = '{20'hE0523, 4'b0100, 4, 1'b1, 1'b0, 1'b0};  // SUBS -> Z=1
    vecs[10] = '{20'h1A000, 4'b0000, 3, 1'b0, 1'b0, 1'b0};  // BNE not taken
    vecs[11] = '{20'hE2905, 4'b0000, 4, 1'b1, 1'b0, 1'b0};  // ADDS -> Z=0
    vecs[12] = '{20'h1A000, 4'b0000, 3, 1'b0, 1'b0, 1'b1};  // BNE taken
    vecs[13] = '{20'hE280F, 4'b0000, 4, 1'b1, 1'b0, 1'b1};  // ADD PC,R0,#4
    vecs[14] = '{20'hE593F, 4'b0000, 5, 1'b1, 1'b0, 1'b1};  // LDR PC
    vecs[15] = '{20'hF2802, 4'b0000, 4, 1'b0, 1'b0, 1'b0};  // cond 1111
    vecs[16] = '{20'hE0312, 4'b0100, 3, 1'b0, 1'b0, 1'b0};  // unimplemented cmd
    vecs[17] = '{20'h02804, 4'b0000, 4, 1'b0, 1'b0, 1'b0};  // Z still 0
    vecs[18] = '{20'hE1110, 4'b0100, 3, 1'b0, 1'b0, 1'b0};  // TST
    vecs[19] = '{20'h02804, 4'b0000, 4, CMP_EN, 1'b0, 1'b0};
    vecs[20] = '{20'hEC000, 4'b0000, 2, 1'b0, 1'b0, 1'b0};  // op 11
    vecs[21] = '{20'hE2905, 4'b0010, 4, 1'b1, 1'b0, 1'b0};  // ADDS -> C=1
    vecs[22] = '{20'hE2101, 4'b0001, 4, 1'b1, 1'b0, 1'b0};  // ANDS keeps C,V
    vecs[23] = '{20'h22802, 4'b0000, 4, 1'b1, 1'b0, 1'b0};  // ADDCS taken
    vecs[24] = '{20'h62802, 4'b0000, 4, 1'b0, 1'b0, 1'b0};  // ADDVS not taken
    v_after_rst = '{20'h22802, 4'b0000, 4, 1'b0, 1'b0, 1'b0};  // C cleared by reset

    reset = 1'b1;
    Instr = 20'h0;
    ALUFlags = 4'h0;
    #2;
    chk("reset write enables", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'h0);
    chk("reset fetch muxes", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}),
        32'({1'b0, 1'b1, 2'b10, 2'b10, 2'b00}));
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("irwrite after release", 32'(IRWrite), 32'd1);

    for (int i = 0; i < 25; i++) run_vec(vecs[i], i);

    // Reset during MEMRD of an LDR: pending write dropped, FSM and flags cleared.
    Instr = 20'hE5938;
    ALUFlags = 4'h0;
    #1;
    chk("ldr fetch irw", 32'(IRWrite), 32'd1);
    repeat (3) next_cycle();
    chk("memrd adrsrc", 32'(AdrSrc), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid-ldr reset enables", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'h0);
    chk("mid-ldr reset muxes", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}),
        32'({1'b0, 1'b1, 2'b10, 2'b10}));
    next_cycle();
    chk("mid-ldr reset held enables", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'h0);
    reset = 1'b0;
    #1;
    chk("irwrite after mid reset", 32'(IRWrite), 32'd1);
    mflags = 4'b0000;
    run_vec(v_after_rst, 25);

    // Directed model runs for the per-cycle control words.
    run_model(20'hE2802, 4'b0000, 1'b1);
    run_model(20'hE0523, 4'b0100, 1'b1);
    run_model(20'h02804, 4'b0000, 1'b1);
    run_model(20'h1A000, 4'b0000, 1'b1);
    run_model(20'hE2905, 4'b0000, 1'b1);
    run_model(20'h1A000, 4'b0000, 1'b1);
    run_model(20'hE1510, 4'b0100, 1'b1);
    run_model(20'hE5837, 4'b0000, 1'b1);
    run_model(20'hE5938, 4'b0000, 1'b1);

    for (int i = 0; i < 200; i++) begin
      logic [19:0] ins;
      ins = 20'($urandom);
      if ($urandom_range(0, 3) == 0) ins[19:16] = 4'hE;
      if ($urandom_range(0, 4) == 0) ins[3:0] = 4'hF;
      run_model(ins, 4'h0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
